// File: rtl/subword_mem.sv
// subword_mem: big-endian byte-addressable data RAM behind valid/ready request/response ports.
// Define SUBWORD_MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of aligning them.
module subword_mem #(
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_write;
    logic [1:0]      r_size;
    logic            r_signed;
    logic [1:0]      r_lane;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic            r_err;

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [31:0]     r_q;

    logic            w_accept;
    logic            w_misalign;
    logic            w_range_err;
    logic            w_err;
    logic [1:0]      w_lane;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_merged;
    logic [31:0]     w_load;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_accept    = req_valid & req_ready;
    assign w_idx       = AW'((req_addr - BASE_ADDR) >> 2);
    assign w_range_err = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) | ({1'b0, req_addr} >= LIMIT);
    assign w_err       = w_range_err | (req_size == 2'b11) | w_misalign;

`ifdef SUBWORD_MEM_ALIGN_CHECK_EN
    assign w_misalign = ((req_size == 2'b01) & req_addr[0]) |
                        ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    assign w_lane     = req_addr[1:0];
`else
    assign w_misalign = 1'b0;
    // Lane is captured already aligned so the datapath never sees an odd half or word offset.
    always_comb begin
        case (req_size)
            2'b01:   w_lane = {req_addr[1], 1'b0};
            2'b10:   w_lane = 2'b00;
            default: w_lane = req_addr[1:0];
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_lane   <= 2'b00;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_lane   <= w_lane;
                r_idx    <= w_idx;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)
                        w_next = RESP;
                    else if (req_write && (req_size == 2'b10))
                        w_next = WRITE;
                    else
                        w_next = FETCH;
                end
            end
            FETCH:   w_next = r_write ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM is not reset; reads happen only in FETCH so r_q stays valid through RESP.
    always_ff @(posedge clk) begin
        if (r_state == FETCH)
            r_q <= r_mem[r_idx];
        if (r_state == WRITE)
            r_mem[r_idx] <= w_merged;
    end

    always_comb begin
        w_merged = r_q;
        case (r_size)
            2'b00: begin
                case (r_lane)
                    2'd0:    w_merged[31:24] = r_wdata[7:0];
                    2'd1:    w_merged[23:16] = r_wdata[7:0];
                    2'd2:    w_merged[15:8]  = r_wdata[7:0];
                    default: w_merged[7:0]   = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_lane[1])
                    w_merged[15:0] = r_wdata[15:0];
                else
                    w_merged[31:16] = r_wdata[15:0];
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_byte = r_q[31:24];
            2'd1:    w_byte = r_q[23:16];
            2'd2:    w_byte = r_q[15:8];
            default: w_byte = r_q[7:0];
        endcase
        w_half = r_lane[1] ? r_q[15:0] : r_q[31:16];
        case (r_size)
            2'b00:   w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            2'b01:   w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            default: w_load = r_q;
        endcase
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_error = resp_valid & r_err;
    assign resp_rdata = (resp_valid & ~r_write & ~r_err) ? w_load : '0;

endmodule

// File: doc/subword_mem.md
# subword_mem

Parametrised, big-endian, byte-addressable data memory with a valid/ready request port and a valid/ready response port. Handles byte, half-word and word loads and stores, with optional sign extension on loads. Sub-word stores are performed internally as read-modify-write on a single-port synchronous RAM. Range and alignment errors are reported per transaction. Sits between the processor load/store unit and on-chip RAM.

## Interface
- `DEPTH_WORDS`, default 32768: number of 32-bit words; power of two, minimum 4.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend byte/half loads; ignored for words and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed on an edge where `resp_valid & resp_ready`.
- `resp_rdata` out 32: load result, zero- or sign-extended; 0 for stores and errors.
- `resp_error` out 1: transaction faulted; no memory access was performed.

## Operation
- Byte order is big-endian.
  - Byte lane k = `addr[1:0]` occupies bits [31-8k : 24-8k].
  - Half at `addr[1]`=0 occupies [31:16]; `addr[1]`=1 occupies [15:0].
- Word index = (`req_addr` − `BASE_ADDR`) >> 2, $clog2(DEPTH_WORDS) bits.
- Error conditions, evaluated at acceptance:
  - `req_addr` < `BASE_ADDR`;
  - `req_addr` ≥ `BASE_ADDR` + 4·`DEPTH_WORDS`;
  - `req_size` = 11;
  - misalignment (see Configuration).
- All request fields are registered at acceptance. Inputs are don't-care afterwards.
- State machine states: IDLE, FETCH, WRITE, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. On acceptance:
  - error → RESP;
  - load → FETCH;
  - sub-word store → FETCH;
  - word store → WRITE.
- FETCH: RAM read issued. Registered RAM output `q` is valid at the end of the cycle.
  - Load → RESP.
  - Sub-word store → WRITE.
- WRITE: merged word written at the end of the cycle, then → RESP.
  - Word store: the merged word is `req_wdata`.
  - Sub-word store: the merged word is `q` with the addressed lane(s) replaced by `req_wdata`.
- RESP: `resp_valid`=1.
  - Loads: `resp_rdata` is the lane extracted from `q` and extended.
  - `q` is stable because no read occurs outside FETCH.
  - Hold until `resp_valid & resp_ready`, then → IDLE.
- `req_ready` is 0 in every state except IDLE. Only one transaction is in flight at a time.
- RAM contents are not initialised and are not affected by `rst`.

## Timing
- Reset values:
  - `req_ready`=1 (IDLE);
  - `resp_valid`=0;
  - `resp_rdata`=0;
  - `resp_error`=0.
- The acceptance edge is E0. `resp_valid` goes high after:
  - error: E0 (1 cycle);
  - load: E1 (2 cycles);
  - word store: E1, with the RAM written at E1;
  - sub-word store: E2, with the read at E1 and the write at E2.
- `resp_rdata` and `resp_error` are stable for the whole time `resp_valid` is high.
- With `resp_ready`=1 during RESP:
  - IDLE follows the next edge;
  - throughput is one load every 3 cycles.
- `rst` asserted mid-transaction:
  - immediate return to IDLE, all outputs at reset values;
  - a store whose write edge has not occurred is dropped;
  - a completed write is kept.
- A load directly following a store to the same word returns the new data, because the store completes before its response.

## Configuration
- `SUBWORD_MEM_ALIGN_CHECK_EN`, defined:
  - a half access with `addr[0]`=1 is an error, `resp_error`=1;
  - a word access with `addr[1:0]`≠0 is an error, `resp_error`=1;
  - no RAM access is performed for these.
- Undefined:
  - no alignment error is ever raised;
  - the low address bits are forced to zero: `addr[0]` for halves, `addr[1:0]` for words;
  - the access proceeds at the aligned address.

## Test plan
- Store word 32'hA1B2C3D4 at 0x10, then load bytes 0x10..0x13, unsigned → A1, B2, C3, D4.
- Same word; store byte 8'h5E at 0x12; load word 0x10 → A1B25ED4, with the store response 3 cycles after acceptance.
- Store half 16'h8001 at 0x22; load half 0x22 signed → FFFF8001; unsigned → 00008001; load word 0x20 → xxxx8001 with the upper half unchanged.
- Load at `BASE_ADDR` + 4·`DEPTH_WORDS` → `resp_error`=1 one cycle after acceptance. Word store to 0x1_FFFC → succeeds.
- Word load 0x13:
  - with the macro → `resp_error`=1;
  - without → returns word 0x10.
- Hold `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_rdata` stable and `req_ready`=0. Assert `rst` during the WRITE of a byte store → a later load shows the old data.
